// File: rtl/mul_arbiter_ctrl.sv
// Two-requester round-robin front end for the shared carry-save multiplier.
// Operands are registered, the multiplier is given a fixed settle budget, then one half is returned.

module multiplier_signed #(
  parameter int unsigned SIZE = 32
) (
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  input  logic              sign,
  input  logic              mix,
  output logic [2*SIZE-1:0] y
);

  localparam int unsigned W = 2 * SIZE;

  logic [W-1:0] ax;
  logic [W-1:0] bx;
  logic [W-1:0] pp;
  logic [W-1:0] acc_s;
  logic [W-1:0] acc_c;
  logic [W-1:0] sum_n;
  logic [W-1:0] carry_n;

  // a is signed for MULH and MULHSU; b only for MULH
  assign ax = {{SIZE{a[SIZE-1] & (sign | mix)}}, a};
  assign bx = {{SIZE{b[SIZE-1] & sign}}, b};

  // Modulo-2^W partial products reduced by a 3:2 carry-save chain, one final carry-propagate add
  always_comb begin
    acc_s   = '0;
    acc_c   = '0;
    pp      = '0;
    sum_n   = '0;
    carry_n = '0;
    for (int i = 0; i < W; i++) begin
      pp      = bx[i] ? (ax << i) : '0;
      sum_n   = acc_s ^ acc_c ^ pp;
      carry_n = ((acc_s & acc_c) | (acc_s & pp) | (acc_c & pp)) << 1;
      acc_s   = sum_n;
      acc_c   = carry_n;
    end
  end

  assign y = acc_s + acc_c;

endmodule

module mul_arbiter_ctrl #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_op,
  input  logic [2*SIZE-1:0] req_a,
  input  logic [2*SIZE-1:0] req_b,
  input  logic              kill,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [SIZE-1:0]   rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [1:0] OpMul    = 2'b00;
  localparam logic [1:0] OpMulh   = 2'b01;
  localparam logic [1:0] OpMulhsu = 2'b10;
  localparam logic [3:0] CntLoad  = 4'(MUL_CYCLES - 1);

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic            id_q, id_d;
  logic            rsp_id_q, rsp_id_d;
  logic [SIZE-1:0] rsp_data_q, rsp_data_d;

  logic            grant_id;
  logic            can_grant;
  logic            accept;
  logic            mul_sign;
  logic            mul_mix;
  logic [2*SIZE-1:0] mul_y;

  // Arbitration is purely combinational and only live in idle
  always_comb begin
    grant_id  = (req_valid == 2'b11) ? rr_q : req_valid[1];
    can_grant = (state_q == StIdle) && !kill && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (can_grant) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign accept = can_grant;

  // Multiplier sees only registered operands so the multicycle path starts at flops
  assign mul_sign = (op_q == OpMulh);
  assign mul_mix  = (op_q == OpMulhsu);

  multiplier_signed #(
    .SIZE (SIZE)
  ) u_mul (
    .a    (a_q),
    .b    (b_q),
    .sign (mul_sign),
    .mix  (mul_mix),
    .y    (mul_y)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = grant_id ? req_a[2*SIZE-1:SIZE] : req_a[SIZE-1:0];
          b_d     = grant_id ? req_b[2*SIZE-1:SIZE] : req_b[SIZE-1:0];
          op_d    = grant_id ? req_op[3:2] : req_op[1:0];
          id_d    = grant_id;
          rr_d    = ~grant_id;
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (kill) begin
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d = (op_q == OpMul) ? mul_y[SIZE-1:0] : mul_y[2*SIZE-1:SIZE];
          rsp_id_d   = id_q;
          state_d    = StDone;
        end
      end
      StDone: begin
        // kill is deliberately ignored here: a finished result always drains
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      cnt_q      <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 2'b00;
      id_q       <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_valid = (state_q == StDone);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mul_arbiter_ctrl.sv
// Directed bench for mul_arbiter_ctrl (SIZE=8, MUL_CYCLES=2) with a response scoreboard.

module tb_mul_arbiter_ctrl;

  localparam int unsigned SIZE = 8;
  localparam int unsigned MC   = 2;

  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [3:0]        req_op;
  logic [2*SIZE-1:0] req_a;
  logic [2*SIZE-1:0] req_b;
  logic              kill;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [SIZE-1:0]   rsp_data;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] sb_q[$];
  logic [8:0] exp_r;

  always #5 clk = ~clk;

  mul_arbiter_ctrl #(
    .SIZE       (SIZE),
    .MUL_CYCLES (MC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .kill      (kill),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: every completed response handshake is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        timeout("unexpected response");
      end else begin
        exp_r = sb_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(exp_r[8]));
        check("rsp_data", 32'(rsp_data), 32'(exp_r[7:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    req_op[2*id +: 2] = op;
    req_a[8*id +: 8]  = a;
    req_b[8*id +: 8]  = b;
    req_valid[id]     = 1'b1;
  endtask

  // Waits for a grant, checks it went to id, optionally books the result, takes the accept edge
  task automatic accept(input int id, input logic [7:0] exp, input bit push);
    int k = 0;
    #1;
    while (req_ready == 2'b00 && k < 20) begin
      step();
      k++;
    end
    if (req_ready == 2'b00) timeout("grant wait");
    check("req_ready grant", 32'(req_ready), 32'(1) << id);
    if (push) sb_q.push_back({id[0], exp});
    step();
  endtask

  task automatic finish_rsp();
    int k = 0;
    while (!rsp_valid && k < 20) begin
      step();
      k++;
    end
    if (!rsp_valid) timeout("rsp_valid wait");
    step();
  endtask

  initial begin
    int edges;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    kill      = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset rsp_data", 32'(rsp_data), 0);
    check("reset rsp_id", 32'(rsp_id), 0);
    check("reset req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single MUL: -3 * 5 low byte, latency counted with the accept edge as edge 1
    set_req(0, MUL, 8'hFD, 8'h05);
    accept(0, 8'hF1, 1'b1);
    req_valid = 2'b00;
    edges = 1;
    check("busy after accept", 32'(busy), 1);
    while (!rsp_valid && edges < 20) begin
      step();
      edges++;
    end
    check("latency edges", 32'(edges), MC + 1);
    step();

    // High-half variants
    set_req(0, MULH, 8'hFD, 8'h05);
    accept(0, 8'hFF, 1'b1);
    req_valid = 2'b00;
    finish_rsp();
    set_req(0, MULHU, 8'hFD, 8'h05);
    accept(0, 8'h04, 1'b1);
    req_valid = 2'b00;
    finish_rsp();
    set_req(0, MULHSU, 8'hFD, 8'h05);
    accept(0, 8'hFF, 1'b1);
    req_valid = 2'b00;
    finish_rsp();
    set_req(1, MULHSU, 8'h05, 8'hFD);
    accept(1, 8'h04, 1'b1);
    req_valid = 2'b00;
    finish_rsp();

    // Both requesters held valid: last grant was 1, so order is 0,1,0,1
    set_req(0, MUL, 8'h07, 8'h06);
    set_req(1, MULHU, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      accept(i % 2, (i % 2) ? 8'hFE : 8'h2A, 1'b1);
      check("req_ready in busy", 32'(req_ready), 0);
      finish_rsp();
    end
    req_valid = 2'b00;

    // Back-pressure in DONE with requester 1 waiting
    rsp_ready = 1'b0;
    set_req(0, MUL, 8'h03, 8'h04);
    accept(0, 8'h0C, 1'b1);
    req_valid = 2'b00;
    set_req(1, MULHU, 8'h10, 8'h10);
    edges = 0;
    while (!rsp_valid && edges < 20) begin
      step();
      edges++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall rsp_valid", 32'(rsp_valid), 1);
      check("stall rsp_data", 32'(rsp_data), 32'h0C);
      check("stall req_ready", 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    accept(1, 8'h01, 1'b1);
    req_valid = 2'b00;
    finish_rsp();

    // kill: blocks grant in idle, aborts in busy, then the other requester proceeds
    set_req(0, MUL, 8'h02, 8'h03);
    set_req(1, MUL, 8'h09, 8'h09);
    kill = 1'b1;
    #1;
    check("kill idle req_ready", 32'(req_ready), 0);
    kill = 1'b0;
    accept(0, 8'h00, 1'b0);
    kill = 1'b1;
    req_valid[0] = 1'b0;
    step();
    kill = 1'b0;
    check("kill busy", 32'(busy), 0);
    check("kill rsp_valid", 32'(rsp_valid), 0);
    accept(1, 8'h51, 1'b1);
    req_valid = 2'b00;
    finish_rsp();

    // Reset during BUSY after a grant to 0 (pointer would otherwise favour 1)
    set_req(0, MULHU, 8'hFF, 8'h02);
    accept(0, 8'h00, 1'b0);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check("rst rsp_valid", 32'(rsp_valid), 0);
    check("rst busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    set_req(0, MULHU, 8'hFF, 8'h02);
    set_req(1, MUL, 8'h01, 8'h01);
    accept(0, 8'h01, 1'b1);
    req_valid = 2'b00;
    finish_rsp();

    edges = 0;
    while (sb_q.size() != 0 && edges < 20) begin
      step();
      edges++;
    end
    check("scoreboard drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
